lsu_mem_master: RTL and testbench

//   Initiator side of the core's 64-bit data-memory port. Accepts one load/store at a time from the
//   MEM stage, drives mem_read/mem_write/write_mask/data_addr/write_data, and returns aligned,

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_mem_master.sv | 230 +++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and helpers for the load/store memory master.
//   - size_e  : access size encoding (byte, half, word, double)
//   - state_e : FSM state encoding; ACC1 exists only when the optional
//               LSU_MISALIGN_SPLIT_EN macro is defined
//   - size_bytes()  : number of bytes for an access size
//   - expand_mask() : byte-enable vector -> 64-bit bit mask
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [63:0] MEM_BASE_DEF = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_SIZE_DEF = 64'h0000_0000_0800_0000;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_RESP = 2'd3
    } state_e;
`endif

    function automatic logic [3:0] size_bytes(input size_e sz);
        return 4'd1 << sz;
    endfunction

    function automatic logic [63:0] expand_mask(input logic [7:0] byte_en);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{byte_en[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for one access.
//   Ports:
//     off        in   3   byte offset of the access inside its doubleword
//     size       in   2   access size (size_e)
//     sign_ext   in   1   sign-extend the load result
//     beat       in   1   0 = first doubleword, 1 = following doubleword
//     wdata      in   64  right-aligned store data
//     rd0, rd1   in   64  first / second doubleword read data (rd1 = 0 if unused)
//     mask       out  64  bit mask of the bytes this beat touches
//     lane_data  out  64  store data shifted into this beat's byte lanes
//     load_data  out  64  merged, truncated and extended load result
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  off,
    input  size_e       size,
    input  logic        sign_ext,
    input  logic        beat,
    input  logic [63:0] wdata,
    input  logic [63:0] rd0,
    input  logic [63:0] rd1,
    output logic [63:0] mask,
    output logic [63:0] lane_data,
    output logic [63:0] load_data
);

    logic [15:0] span;
    logic [6:0]  lo_shift;
    logic [6:0]  hi_shift;
    logic [63:0] merged;

    // Byte enables over two consecutive doublewords: low byte covers the first
    // beat, high byte the spill-over into the next doubleword.
    assign span     = ((16'h1 << size_bytes(size)) - 16'h1) << off;
    assign lo_shift = {1'b0, off, 3'b000};
    // At off = 0 this is 64, which shifts everything out -- exactly what an
    // unused second beat should contribute.
    assign hi_shift = 7'd64 - lo_shift;

    assign mask      = expand_mask(beat ? span[15:8] : span[7:0]);
    assign lane_data = beat ? (wdata >> hi_shift) : (wdata << lo_shift);
    assign merged    = (rd0 >> lo_shift) | (rd1 << hi_shift);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        load_data = merged;
        case (size)
            SZ_B:    load_data = {{56{sign_ext & merged[7]}},  merged[7:0]};
            SZ_H:    load_data = {{48{sign_ext & merged[15]}}, merged[15:0]};
            SZ_W:    load_data = {{32{sign_ext & merged[31]}}, merged[31:0]};
            default: load_data = merged;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// ----------------------------------------------------------------------------
// lsu_mem_master
//   Initiator side of the 64-bit data-memory port. Takes one load/store at a
//   time from the MEM stage, runs one (or two) doubleword beats on the memory
//   port and returns aligned, extended load data.
//
//   Optional feature macro: LSU_MISALIGN_SPLIT_EN
//     defined     : accesses crossing a doubleword boundary run as ACC0 + ACC1
//     not defined : such accesses complete immediately with resp_err = 1
//
//   Ports:
//     clk, rst_n                clock, asynchronous active-low reset
//     req_valid/req_ready       request handshake (ready only in IDLE)
//     req_wen, req_size,        store flag, size (B/H/W/D), load sign-extend,
//     req_signed, req_addr,     byte address, right-aligned store data
//     req_wdata
//     resp_valid/resp_ready     response handshake (held until accepted)
//     resp_rdata, resp_err      load result (0 for stores/errors), error flag
//     mem_read, mem_write       memory strobes, active only during ACC beats
//     write_mask, data_addr,    bit mask, doubleword address, lane-shifted
//     write_data                store data
//     read_data                 combinational read of the addressed doubleword
// ----------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter logic [63:0] MEM_BASE = MEM_BASE_DEF,
    parameter logic [63:0] MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] write_mask,
    output logic [63:0] data_addr,
    output logic [63:0] write_data,
    input  logic [63:0] read_data
);

    localparam logic [63:0] MEM_END = MEM_BASE + MEM_SIZE;

    state_e      state;
    state_e      state_next;

    logic [60:0] dw_q;
    logic [2:0]  off_q;
    size_e       size_q;
    logic        wen_q;
    logic        sign_q;
    logic        err_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;

    logic        addr_legal;
    logic        req_fault;

    logic        align_beat;
    logic [63:0] align_rd0;
    logic [63:0] align_rd1;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
    logic [63:0] load_data;

    assign addr_legal = (req_addr >= MEM_BASE) && (req_addr < MEM_END);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [63:0] rd0_q;
    logic        acc_cross;

    assign acc_cross  = ({1'b0, off_q} + size_bytes(size_q)) > 4'd8;
    assign req_fault  = !addr_legal;
    // The second beat merges the first doubleword captured during ACC0 with
    // the live read of the following one.
    assign align_beat = (state == ST_ACC1);
    assign align_rd0  = align_beat ? rd0_q : read_data;
    assign align_rd1  = align_beat ? read_data : 64'h0;
`else
    logic        req_cross;

    assign req_cross  = ({1'b0, req_addr[2:0]} + size_bytes(size_e'(req_size))) > 4'd8;
    assign req_fault  = !addr_legal || req_cross;
    assign align_beat = 1'b0;
    assign align_rd0  = read_data;
    assign align_rd1  = 64'h0;
`endif

    lsu_align u_align (
        .off       (off_q),
        .size      (size_q),
        .sign_ext  (sign_q),
        .beat      (align_beat),
        .wdata     (wdata_q),
        .rd0       (align_rd0),
        .rd1       (align_rd1),
        .mask      (lane_mask),
        .lane_data (lane_data),
        .load_data (load_data)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    // Faulting requests skip the memory beats entirely.
                    state_next = req_fault ? ST_RESP : ST_ACC0;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC0: state_next = acc_cross ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_next = ST_RESP;
`else
            ST_ACC0: state_next = ST_RESP;
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        write_mask = 64'h0;
        data_addr  = 64'h0;
        write_data = 64'h0;
        case (state)
            ST_ACC0: begin
                mem_read   = !wen_q;
                mem_write  = wen_q;
                data_addr  = {dw_q, 3'b000};
                write_mask = wen_q ? lane_mask : 64'h0;
                write_data = wen_q ? lane_data : 64'h0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC1: begin
                mem_read   = !wen_q;
                mem_write  = wen_q;
                data_addr  = {dw_q + 61'd1, 3'b000};
                write_mask = wen_q ? lane_mask : 64'h0;
                write_data = wen_q ? lane_data : 64'h0;
            end
`endif
            default: ;
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    // ---------------- Request / response datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dw_q    <= '0;
            off_q   <= '0;
            size_q  <= SZ_B;
            wen_q   <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            rd0_q   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        dw_q    <= req_addr[63:3];
                        off_q   <= req_addr[2:0];
                        size_q  <= size_e'(req_size);
                        wen_q   <= req_wen;
                        sign_q  <= req_signed;
                        wdata_q <= req_wdata;
                        err_q   <= req_fault;
                        // Stores and faults report zero data.
                        rdata_q <= '0;
                    end
                end
                ST_ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    rd0_q <= read_data;
`endif
                    // For a crossing load this partial result is overwritten in ACC1.
                    if (!wen_q) begin
                        rdata_q <= load_data;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_ACC1: begin
                    if (!wen_q) begin
                        rdata_q <= load_data;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_master
//   Directed self-checking bench for lsu_mem_master with a small byte-masked
//   doubleword memory attached to the memory port. Expected values are
//   hand-computed constants. Crossing-access expectations follow
//   LSU_MISALIGN_SPLIT_EN.
// ----------------------------------------------------------------------------
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] write_mask;
    logic [63:0] data_addr;
    logic [63:0] write_data;
    logic [63:0] read_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .write_mask (write_mask),
        .data_addr  (data_addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    // Small memory: 16 doublewords, aliased by data_addr[6:3].
    logic [63:0] mem [16];
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mem_write) begin
            mem[data_addr[6:3]] <= (mem[data_addr[6:3]] & ~write_mask) | (write_data & write_mask);
        end
    end

    assign read_data = mem[data_addr[6:3]];

    // Observations of the most recent transaction.
    int          lat;
    int          beats;
    int          n_rd;
    logic [63:0] b_addr [4];
    logic [63:0] b_mask [4];
    logic [63:0] b_data [4];
    logic [63:0] got_rdata;
    logic        got_err;

    task automatic do_req(input logic wen, input logic [1:0] size, input logic sgn,
                          input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        lat   = 0;
        beats = 0;
        n_rd  = 0;
        for (int i = 0; i < 4; i++) begin
            b_addr[i] = '0;
            b_mask[i] = '0;
            b_data[i] = '0;
        end
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_read || mem_write) begin
                if (beats < 4) begin
                    b_addr[beats] = data_addr;
                    b_mask[beats] = write_mask;
                    b_data[beats] = write_data;
                end
                beats++;
            end
            if (mem_read) n_rd++;
        end while (!resp_valid && lat < 20);
        got_rdata = resp_rdata;
        got_err   = resp_err;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready  !== 1'b1)  begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_err   !== 1'b0)  begin n_bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 64'h0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        n_cmp++; if (mem_read   !== 1'b0)  begin n_bad++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        n_cmp++; if (mem_write  !== 1'b0)  begin n_bad++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
        n_cmp++; if (write_mask !== 64'h0) begin n_bad++; $display("FAIL rst_write_mask: got %h want 0", write_mask); end
        n_cmp++; if (data_addr  !== 64'h0) begin n_bad++; $display("FAIL rst_data_addr: got %h want 0", data_addr); end
        n_cmp++; if (write_data !== 64'h0) begin n_bad++; $display("FAIL rst_write_data: got %h want 0", write_data); end
        rst_n     = 1'b1;
        mem_clear = 1'b0;
    endtask

    task automatic test_store_d();
        do_req(1'b1, 2'd3, 1'b0, 64'h8000_0000, 64'h1122_3344_5566_7788);
        n_cmp++; if (lat       !== 2)                     begin n_bad++; $display("FAIL sd_lat: got %0d want 2", lat); end
        n_cmp++; if (beats     !== 1)                     begin n_bad++; $display("FAIL sd_beats: got %0d want 1", beats); end
        n_cmp++; if (n_rd      !== 0)                     begin n_bad++; $display("FAIL sd_reads: got %0d want 0", n_rd); end
        n_cmp++; if (b_mask[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL sd_mask: got %h want all ones", b_mask[0]); end
        n_cmp++; if (b_addr[0] !== 64'h8000_0000)         begin n_bad++; $display("FAIL sd_addr: got %h want 80000000", b_addr[0]); end
        n_cmp++; if (b_data[0] !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL sd_wdata: got %h want 1122334455667788", b_data[0]); end
        n_cmp++; if (got_err   !== 1'b0)                  begin n_bad++; $display("FAIL sd_err: got %b want 0", got_err); end
        n_cmp++; if (got_rdata !== 64'h0)                 begin n_bad++; $display("FAIL sd_rdata: got %h want 0", got_rdata); end
        n_cmp++; if (mem[0]    !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL sd_mem: got %h want 1122334455667788", mem[0]); end
        do_req(1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0);
        n_cmp++; if (got_rdata !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL ld_rdata: got %h want 1122334455667788", got_rdata); end
        n_cmp++; if (n_rd      !== 1)                     begin n_bad++; $display("FAIL ld_reads: got %0d want 1", n_rd); end
    endtask

    task automatic test_subword();
        // Upper bytes of the store data are junk that must stay out of memory.
        do_req(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h1234_5678_9ABC_DEAB);
        n_cmp++; if (b_mask[0] !== 64'h0000_FF00_0000_0000) begin n_bad++; $display("FAIL sb_mask: got %h want 0000ff0000000000", b_mask[0]); end
        n_cmp++; if (b_data[0] !== 64'hBCDE_AB00_0000_0000) begin n_bad++; $display("FAIL sb_wdata: got %h want bcdeab0000000000", b_data[0]); end
        n_cmp++; if (mem[0]    !== 64'h1122_AB44_5566_7788) begin n_bad++; $display("FAIL sb_mem: got %h want 1122ab4455667788", mem[0]); end
        do_req(1'b0, 2'd0, 1'b1, 64'h8000_0005, 64'h0);
        n_cmp++; if (got_rdata !== 64'hFFFF_FFFF_FFFF_FFAB) begin n_bad++; $display("FAIL lb_signed: got %h want ffffffffffffffab", got_rdata); end
        do_req(1'b0, 2'd0, 1'b0, 64'h8000_0005, 64'h0);
        n_cmp++; if (got_rdata !== 64'h0000_0000_0000_00AB) begin n_bad++; $display("FAIL lb_unsigned: got %h want ab", got_rdata); end
        do_req(1'b0, 2'd1, 1'b1, 64'h8000_0004, 64'h0);
        n_cmp++; if (got_rdata !== 64'hFFFF_FFFF_FFFF_AB44) begin n_bad++; $display("FAIL lh_signed: got %h want ffffffffffffab44", got_rdata); end
        // Word at offset 2 stays inside one doubleword: legal, single beat.
        do_req(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0);
        n_cmp++; if (got_rdata !== 64'h0000_0000_AB44_5566) begin n_bad++; $display("FAIL lw_off2: got %h want ab445566", got_rdata); end
        n_cmp++; if (lat       !== 2)                       begin n_bad++; $display("FAIL lw_off2_lat: got %0d want 2", lat); end
        n_cmp++; if (got_err   !== 1'b0)                    begin n_bad++; $display("FAIL lw_off2_err: got %b want 0", got_err); end
        do_req(1'b0, 2'd2, 1'b1, 64'h8000_0002, 64'h0);
        n_cmp++; if (got_rdata !== 64'hFFFF_FFFF_AB44_5566) begin n_bad++; $display("FAIL lw_off2_signed: got %h want ffffffffab445566", got_rdata); end
    endtask

    task automatic test_cross();
        // Bytes 0x11,0x22 at ...06/07 and 0x33,0x44 at ...08/09.
        do_req(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h2211);
        do_req(1'b1, 2'd1, 1'b0, 64'h8000_0008, 64'h4433);
        n_cmp++; if (mem[1] !== 64'h0000_0000_0000_4433) begin n_bad++; $display("FAIL cross_setup_mem1: got %h want 4433", mem[1]); end
        do_req(1'b0, 2'd2, 1'b0, 64'h8000_0006, 64'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        n_cmp++; if (lat       !== 3)              begin n_bad++; $display("FAIL lw_cross_lat: got %0d want 3", lat); end
        n_cmp++; if (n_rd      !== 2)              begin n_bad++; $display("FAIL lw_cross_reads: got %0d want 2", n_rd); end
        n_cmp++; if (b_addr[0] !== 64'h8000_0000)  begin n_bad++; $display("FAIL lw_cross_addr0: got %h want 80000000", b_addr[0]); end
        n_cmp++; if (b_addr[1] !== 64'h8000_0008)  begin n_bad++; $display("FAIL lw_cross_addr1: got %h want 80000008", b_addr[1]); end
        n_cmp++; if (got_rdata !== 64'h4433_2211)  begin n_bad++; $display("FAIL lw_cross_rdata: got %h want 44332211", got_rdata); end
        n_cmp++; if (got_err   !== 1'b0)           begin n_bad++; $display("FAIL lw_cross_err: got %b want 0", got_err); end
`else
        n_cmp++; if (lat       !== 1)              begin n_bad++; $display("FAIL lw_cross_lat: got %0d want 1", lat); end
        n_cmp++; if (n_rd      !== 0)              begin n_bad++; $display("FAIL lw_cross_reads: got %0d want 0", n_rd); end
        n_cmp++; if (got_rdata !== 64'h0)          begin n_bad++; $display("FAIL lw_cross_rdata: got %h want 0", got_rdata); end
        n_cmp++; if (got_err   !== 1'b1)           begin n_bad++; $display("FAIL lw_cross_err: got %b want 1", got_err); end
`endif
        do_req(1'b1, 2'd2, 1'b0, 64'h8000_000E, 64'h0000_0000_DDCC_BBAA);
`ifdef LSU_MISALIGN_SPLIT_EN
        n_cmp++; if (beats     !== 2)                     begin n_bad++; $display("FAIL sw_cross_beats: got %0d want 2", beats); end
        n_cmp++; if (b_mask[0] !== 64'hFFFF_0000_0000_0000) begin n_bad++; $display("FAIL sw_cross_mask0: got %h want ffff000000000000", b_mask[0]); end
        n_cmp++; if (b_data[0] !== 64'hBBAA_0000_0000_0000) begin n_bad++; $display("FAIL sw_cross_data0: got %h want bbaa000000000000", b_data[0]); end
        n_cmp++; if (b_mask[1] !== 64'h0000_0000_0000_FFFF) begin n_bad++; $display("FAIL sw_cross_mask1: got %h want ffff", b_mask[1]); end
        n_cmp++; if (b_data[1] !== 64'h0000_0000_0000_DDCC) begin n_bad++; $display("FAIL sw_cross_data1: got %h want ddcc", b_data[1]); end
        n_cmp++; if (b_addr[1] !== 64'h8000_0010)         begin n_bad++; $display("FAIL sw_cross_addr1: got %h want 80000010", b_addr[1]); end
        n_cmp++; if (mem[1]    !== 64'hBBAA_0000_0000_4433) begin n_bad++; $display("FAIL sw_cross_mem1: got %h want bbaa000000004433", mem[1]); end
        n_cmp++; if (mem[2]    !== 64'h0000_0000_0000_DDCC) begin n_bad++; $display("FAIL sw_cross_mem2: got %h want ddcc", mem[2]); end
        do_req(1'b0, 2'd2, 1'b1, 64'h8000_000E, 64'h0);
        n_cmp++; if (got_rdata !== 64'hFFFF_FFFF_DDCC_BBAA) begin n_bad++; $display("FAIL lw_cross_back: got %h want ffffffffddccbbaa", got_rdata); end
`else
        n_cmp++; if (beats     !== 0)                     begin n_bad++; $display("FAIL sw_cross_beats: got %0d want 0", beats); end
        n_cmp++; if (got_err   !== 1'b1)                  begin n_bad++; $display("FAIL sw_cross_err: got %b want 1", got_err); end
        n_cmp++; if (mem[1]    !== 64'h0000_0000_0000_4433) begin n_bad++; $display("FAIL sw_cross_mem1: got %h want 4433", mem[1]); end
        n_cmp++; if (mem[2]    !== 64'h0)                 begin n_bad++; $display("FAIL sw_cross_mem2: got %h want 0", mem[2]); end
`endif
    endtask

    task automatic test_illegal();
        do_req(1'b0, 2'd3, 1'b0, 64'h7FFF_FFF8, 64'h0);
        n_cmp++; if (got_err   !== 1'b1)  begin n_bad++; $display("FAIL below_err: got %b want 1", got_err); end
        n_cmp++; if (got_rdata !== 64'h0) begin n_bad++; $display("FAIL below_rdata: got %h want 0", got_rdata); end
        n_cmp++; if (n_rd      !== 0)     begin n_bad++; $display("FAIL below_reads: got %0d want 0", n_rd); end
        n_cmp++; if (lat       !== 1)     begin n_bad++; $display("FAIL below_lat: got %0d want 1", lat); end
        do_req(1'b1, 2'd3, 1'b0, 64'h8800_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        n_cmp++; if (got_err   !== 1'b1)  begin n_bad++; $display("FAIL above_err: got %b want 1", got_err); end
        n_cmp++; if (beats     !== 0)     begin n_bad++; $display("FAIL above_beats: got %0d want 0", beats); end
        do_req(1'b0, 2'd3, 1'b0, 64'h87FF_FFF8, 64'h0);
        n_cmp++; if (got_err   !== 1'b0)  begin n_bad++; $display("FAIL top_err: got %b want 0", got_err); end
        n_cmp++; if (lat       !== 2)     begin n_bad++; $display("FAIL top_lat: got %0d want 2", lat); end
        n_cmp++; if (got_rdata !== 64'h0) begin n_bad++; $display("FAIL top_rdata: got %h want 0", got_rdata); end
    endtask

    task automatic test_hold();
        int wait_cnt;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_size   = 2'd3;
        req_signed = 1'b0;
        req_addr   = 64'h8000_0000;
        wait_cnt   = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            wait_cnt++;
        end while (!resp_valid && wait_cnt < 20);
        n_cmp++; if (wait_cnt !== 2) begin n_bad++; $display("FAIL hold_lat: got %0d want 2", wait_cnt); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, resp_valid); end
            n_cmp++; if (resp_rdata !== 64'h2211_AB44_5566_7788) begin n_bad++; $display("FAIL hold_rdata[%0d]: got %h want 2211ab4455667788", i, resp_rdata); end
            n_cmp++; if (req_ready  !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b want 0", i, req_ready); end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready  !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid: got %b want 0", resp_valid); end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = 1'b1;
        req_size   = 2'd3;
        req_signed = 1'b0;
        req_addr   = 64'h8000_0018;
        req_wdata  = 64'hDEAD_BEEF_0000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL abort_pre_write: got %b want 1", mem_write); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_write  !== 1'b0)  begin n_bad++; $display("FAIL abort_write: got %b want 0", mem_write); end
        n_cmp++; if (write_mask !== 64'h0) begin n_bad++; $display("FAIL abort_mask: got %h want 0", write_mask); end
        n_cmp++; if (req_ready  !== 1'b1)  begin n_bad++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (mem[3] !== 64'h0) begin n_bad++; $display("FAIL abort_mem: got %h want 0", mem[3]); end
        do_req(1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'h0);
        n_cmp++; if (got_rdata !== 64'h0) begin n_bad++; $display("FAIL abort_reload: got %h want 0", got_rdata); end
        n_cmp++; if (lat       !== 2)     begin n_bad++; $display("FAIL abort_reload_lat: got %0d want 2", lat); end
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_clear  = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 64'h0;
        req_wdata  = 64'h0;
        resp_ready = 1'b1;
        test_reset();
        test_store_d();
        test_subword();
        test_cross();
        test_illegal();
        test_hold();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run within 200000 time units, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
